// File: rtl/priority_encoder_4x2.sv
// Registered 4-to-2 priority encoder with zero flag and sample-valid strobe.
// Define PRIORITY_ENCODER_4X2_CHG_EN to add the chg output-change pulse.
module priority_encoder_4x2 #(
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] in,
    output logic [1:0] out,
    output logic       z,
`ifdef PRIORITY_ENCODER_4X2_CHG_EN
    output logic       chg,
`endif
    output logic       valid
);

    logic [1:0] enc_out;
    logic       enc_z;

    // Explicit if/else-if chain so X on lower-priority bits never reaches the result.
    always_comb begin
        enc_out = '0;
        enc_z   = 1'b0;
        if (LSB_FIRST) begin
            if (in[0])      enc_out = 2'd0;
            else if (in[1]) enc_out = 2'd1;
            else if (in[2]) enc_out = 2'd2;
            else if (in[3]) enc_out = 2'd3;
            else            enc_z   = 1'b1;
        end else begin
            if (in[3])      enc_out = 2'd3;
            else if (in[2]) enc_out = 2'd2;
            else if (in[1]) enc_out = 2'd1;
            else if (in[0]) enc_out = 2'd0;
            else            enc_z   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out   <= '0;
            z     <= 1'b1;
            valid <= 1'b0;
        end else begin
            valid <= en;
            if (en) begin
                out <= enc_out;
                z   <= enc_z;
            end
        end
    end

`ifdef PRIORITY_ENCODER_4X2_CHG_EN
    // Compared against the held registers, so the first post-reset sample sees {00,1}.
    always_ff @(posedge clk) begin
        if (rst)
            chg <= 1'b0;
        else
            chg <= en && ({enc_out, enc_z} != {out, z});
    end
`endif

endmodule

// File: tb/tb_priority_encoder_4x2.sv
// Directed self-checking bench for priority_encoder_4x2, covering both
// LSB_FIRST settings side by side on shared stimulus.
module tb_priority_encoder_4x2;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] in;
    logic [1:0] out0, out1;
    logic       z0, z1, valid0, valid1;
`ifdef PRIORITY_ENCODER_4X2_CHG_EN
    logic       chg0, chg1;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    priority_encoder_4x2 #(.LSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .in(in),
        .out(out0), .z(z0),
`ifdef PRIORITY_ENCODER_4X2_CHG_EN
        .chg(chg0),
`endif
        .valid(valid0)
    );

    priority_encoder_4x2 #(.LSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .in(in),
        .out(out1), .z(z1),
`ifdef PRIORITY_ENCODER_4X2_CHG_EN
        .chg(chg1),
`endif
        .valid(valid1)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling outputs.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; in = 4'b1111;
        step(); step();
        check("reset_out0",   {2'b0, out0},   4'b0000);
        check("reset_z0",     {3'b0, z0},     4'b0001);
        check("reset_valid0", {3'b0, valid0}, 4'b0000);
        check("reset_out1",   {2'b0, out1},   4'b0000);
        check("reset_z1",     {3'b0, z1},     4'b0001);

        // Priority sweep, MSB first
        rst = 1'b0; in = 4'b0000; step();
        check("sweep_0000", {1'b0, out0, z0}, 4'b0001);
        check("sweep_valid", {3'b0, valid0}, 4'b0001);
        in = 4'b0001; step();
        check("sweep_0001", {1'b0, out0, z0}, 4'b0000);
        in = 4'b001x; step();
        check("sweep_001x", {1'b0, out0, z0}, 4'b0010);
        in = 4'b01xx; step();
        check("sweep_01xx", {1'b0, out0, z0}, 4'b0100);
        in = 4'b1xxx; step();
        check("sweep_1xxx", {1'b0, out0, z0}, 4'b0110);

        // Hold while en is low
        in = 4'b0100; step();
        check("hold_sample", {1'b0, out0, z0}, 4'b0100);
        en = 1'b0; in = 4'b1000; step();
        check("hold_out",   {1'b0, out0, z0}, 4'b0100);
        check("hold_valid", {3'b0, valid0},   4'b0000);
        step();
        check("hold_out2",  {1'b0, out0, z0}, 4'b0100);

        // LSB-first vs MSB-first on the same vectors
        en = 1'b1; in = 4'b1010; step();
        check("lsb_1010",  {1'b0, out1, z1}, 4'b0010);
        check("msb_1010",  {1'b0, out0, z0}, 4'b0110);
        in = 4'b1000; step();
        check("lsb_1000",  {1'b0, out1, z1}, 4'b0110);
        in = 4'b0000; step();
        check("lsb_0000",  {1'b0, out1, z1}, 4'b0001);

        // Reset wins over en; first sample needs en=1 after reset
        in = 4'b1000; step();
        check("pre_rst", {1'b0, out0, z0}, 4'b0110);
        rst = 1'b1; step();
        check("rst_prio_out",   {1'b0, out0, z0}, 4'b0001);
        check("rst_prio_valid", {3'b0, valid0},   4'b0000);
        rst = 1'b0; en = 1'b0; step();
        check("post_rst_idle_out",   {1'b0, out0, z0}, 4'b0001);
        check("post_rst_idle_valid", {3'b0, valid0},   4'b0000);
        en = 1'b1; in = 4'b0010; step();
        check("post_rst_first", {1'b0, out0, z0}, 4'b0010);
        check("post_rst_valid", {3'b0, valid0},   4'b0001);
        check("post_rst_lsb",   {1'b0, out1, z1}, 4'b0010);

`ifdef PRIORITY_ENCODER_4X2_CHG_EN
        rst = 1'b1; step();
        check("chg_reset", {2'b0, chg0, chg1}, 4'b0000);
        rst = 1'b0; in = 4'b0000; step();
        check("chg_zero_after_rst", {2'b0, chg0, chg1}, 4'b0000);
        in = 4'b0100; step();
        check("chg_first",  {2'b0, chg0, chg1}, 4'b0011);
        step();
        check("chg_repeat", {2'b0, chg0, chg1}, 4'b0000);
        in = 4'b0001; step();
        check("chg_third",  {2'b0, chg0, chg1}, 4'b0011);
        en = 1'b0; in = 4'b1000; step();
        check("chg_idle",   {2'b0, chg0, chg1}, 4'b0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
